// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the dual-write-port data memory.
package data_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned ADDR_LSB   = 2;
  localparam int unsigned MAX_DATA_W = 128;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  // Ceiling log2 for sizing the word index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p * 2) r = r + 1;
    return r;
  endfunction

  // Replace the bytes of old_w selected by be with the matching bytes of d.
  function automatic logic [MAX_DATA_W-1:0] be_merge(input logic [MAX_DATA_W-1:0] old_w,
                                                     input logic [MAX_DATA_W-1:0] d,
                                                     input logic [MAX_BE_W-1:0]   be);
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int unsigned k = 0; k < MAX_BE_W; k++) begin
      if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_mem_init_seq.sv
// Reset-time initialisation sequencer: walks every entry once, then enables traffic.
module data_mem_init_seq
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned INIT_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              init_we_c,
  output logic [IDX_W-1:0]  init_idx_c,
  output logic [DATA_W-1:0] init_data_c
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // State, counter and registered busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == INIT);
    end
  end

  // Next state and init write port; INIT writes one entry per cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_we_c   = 1'b0;
    init_idx_c  = cnt_q;
    init_data_c = '0;
    case (state_q)
      INIT: begin
        init_we_c = 1'b1;
        if (INIT_MODE == 1) init_data_c = DATA_W'(cnt_q);
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_dp.sv
// Dual-write-port, single-read-port word-addressed data memory with registered read.
module data_mem_dp
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned INIT_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_wr,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                mem_wr_comp,
  input  logic [ADDR_W-1:0]   wr_addr_c,
  input  logic [DATA_W-1:0]   wr_data_c,
  input  logic [DATA_W/8-1:0] wr_be_c,
  input  logic                mem_rd,
  input  logic                mem_rd_comp,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                addr_err
);

  localparam int unsigned IDX_W = clog2(DEPTH);

  // Aligned and within the array; out-of-range addresses are never aliased.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[ADDR_LSB-1:0] == '0) && ((a >> (IDX_W + ADDR_LSB)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[IDX_W+ADDR_LSB-1:ADDR_LSB];
  endfunction

  logic              init_we_c;
  logic [IDX_W-1:0]  init_idx_c;
  logic [DATA_W-1:0] init_data_c;

  data_mem_init_seq #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .INIT_MODE(INIT_MODE)
  ) u_init_seq (
    .clk        (clk),
    .reset      (reset),
    .busy       (busy),
    .init_we_c  (init_we_c),
    .init_idx_c (init_idx_c),
    .init_data_c(init_data_c)
  );

  logic             wrp_ok, wrc_ok, rd_req, rd_ok, any_err;
  logic [IDX_W-1:0] idx_p, idx_c, idx_r;

  assign idx_p   = idx_of(wr_addr);
  assign idx_c   = idx_of(wr_addr_c);
  assign idx_r   = idx_of(rd_addr);
  assign wrp_ok  = !busy && mem_wr && addr_ok(wr_addr);
  assign wrc_ok  = !busy && mem_wr_comp && addr_ok(wr_addr_c);
  assign rd_req  = !busy && (mem_rd || mem_rd_comp);
  assign rd_ok   = rd_req && addr_ok(rd_addr);
  assign any_err = !busy && ((mem_wr && !addr_ok(wr_addr)) ||
                             (mem_wr_comp && !addr_ok(wr_addr_c)) ||
                             (rd_req && !addr_ok(rd_addr)));

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Per-entry next value: companion merged first so primary bytes win on overlap.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic [DATA_W-1:0] after_c, after_p;
    assign after_c = (wrc_ok && idx_c == IDX_W'(g))
                   ? DATA_W'(be_merge(MAX_DATA_W'(mem_q[g]), MAX_DATA_W'(wr_data_c),
                                      MAX_BE_W'(wr_be_c)))
                   : mem_q[g];
    assign after_p = (wrp_ok && idx_p == IDX_W'(g))
                   ? DATA_W'(be_merge(MAX_DATA_W'(after_c), MAX_DATA_W'(wr_data),
                                      MAX_BE_W'(wr_be)))
                   : after_c;
    assign mem_d[g] = (init_we_c && init_idx_c == IDX_W'(g)) ? init_data_c : after_p;

    // Storage entry; contents are reloaded by the init sequencer after reset.
    always_ff @(posedge clk) begin
      mem_q[g] <= mem_d[g];
    end
  end

  // Read register (write-first via mem_d) and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      addr_err <= any_err;
      if (rd_ok) begin
        rd_data  <= mem_d[idx_r];
        rd_valid <= 1'b1;
      end else if (rd_req) begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_dp.sv
// Directed scoreboard bench for data_mem_dp (DEPTH=16, INIT_MODE=1).
module tb_data_mem_dp;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_wr, mem_wr_comp, mem_rd, mem_rd_comp;
  logic [AW-1:0] wr_addr, wr_addr_c, rd_addr;
  logic [DW-1:0] wr_data, wr_data_c, rd_data;
  logic [3:0]    wr_be, wr_be_c;
  logic          rd_valid, busy, addr_err;

  data_mem_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_MODE(1)) dut (
    .clk(clk), .reset(reset),
    .mem_wr(mem_wr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .mem_wr_comp(mem_wr_comp), .wr_addr_c(wr_addr_c), .wr_data_c(wr_data_c), .wr_be_c(wr_be_c),
    .mem_rd(mem_rd), .mem_rd_comp(mem_rd_comp), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] last_data;
  logic        exp_err;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic valid_addr(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:6] == 26'd0);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) model[a[5:2]][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic idle();
    mem_wr = 1'b0; mem_wr_comp = 1'b0; mem_rd = 1'b0; mem_rd_comp = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0;
    wr_addr_c = '0; wr_data_c = '0; wr_be_c = '0; rd_addr = '0;
  endtask

  // Companion write; call before wr() in a shared cycle so the primary overlays it.
  task automatic wr_c(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_wr_comp = 1'b1; wr_addr_c = a; wr_data_c = d; wr_be_c = be;
    if (valid_addr(a)) model_write(a, d, be); else exp_err = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_wr = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    if (valid_addr(a)) model_write(a, d, be); else exp_err = 1'b1;
  endtask

  // Read; issued after same-cycle writes so the expectation is write-first.
  task automatic rd(input logic [31:0] a, input bit comp);
    if (comp) mem_rd_comp = 1'b1; else mem_rd = 1'b1;
    rd_addr = a;
    if (valid_addr(a)) exp_q.push_back(model[a[5:2]]);
    else begin exp_err = 1'b1; last_data = '0; end
  endtask

  // Clock one cycle, return inputs to idle and check outputs against the scoreboard.
  task automatic step(input string tag);
    logic [31:0] d;
    @(posedge clk); #1;
    idle();
    chk({tag, "/addr_err"}, 32'(addr_err), 32'(exp_err));
    exp_err = 1'b0;
    if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      chk({tag, "/rd_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "/rd_data"}, rd_data, d);
      last_data = d;
    end else begin
      chk({tag, "/rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "/rd_hold"}, rd_data, last_data);
    end
  endtask

  // Run the init window with traffic applied; every request must be ignored.
  task automatic run_init(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      mem_wr = 1'b1; wr_addr = 32'h4; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
      mem_wr_comp = 1'b1; wr_addr_c = 32'h41; wr_data_c = 32'h5555_5555; wr_be_c = 4'hF;
      mem_rd = 1'b1; rd_addr = 32'h41;
      cnt++;
      @(posedge clk); #1;
      chk("init/rd_valid", 32'(rd_valid), 32'd0);
      chk("init/addr_err", 32'(addr_err), 32'd0);
      chk("init/rd_data", rd_data, 32'd0);
    end
    idle();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);
    last_data = '0;
  endtask

  initial begin
    reset = 1'b0; exp_err = 1'b0; last_data = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", 32'(busy), 32'd1);
    chk("reset/rd_valid", 32'(rd_valid), 32'd0);
    chk("reset/rd_data", rd_data, 32'd0);
    chk("reset/addr_err", 32'(addr_err), 32'd0);
    reset = 1'b1;
    run_init(n);
    chk("init_len", 32'(n), 32'd16);
    chk("run/busy", 32'(busy), 32'd0);

    rd(32'h14, 1'b0); step("t1_rd14");
    wr(32'h08, 32'hDEAD_BEEF, 4'b0011); step("t2_wr");
    rd(32'h08, 1'b1); step("t2_rd08");
    wr_c(32'h0C, 32'h2222_2222, 4'b1111); wr(32'h0C, 32'h1111_1111, 4'b0101); step("t3_wr");
    rd(32'h0C, 1'b0); step("t3_rd0c");
    wr(32'h10, 32'hA5A5_A5A5, 4'hF); rd(32'h10, 1'b0); step("t4_wr_rd10");
    step("t4_hold");
    wr(32'h18, 32'hCAFE_F00D, 4'hF); wr_c(32'h1C, 32'h1234_5678, 4'b1000); step("dual_diff");
    rd(32'h18, 1'b1); step("rd18");
    rd(32'h1C, 1'b0); step("rd1c");

    wr(32'h41, 32'h9999_9999, 4'hF); step("t5_wr41");
    step("t5_err_clear");
    wr(32'h40, 32'h7777_7777, 4'hF); step("t5_wr40");
    wr_c(32'h3E, 32'h6666_6666, 4'hF); step("t5_wrc3e");
    rd(32'h40, 1'b0); step("t5_rd40");
    rd(32'h8000_0000, 1'b1); step("t5_rd_hi");
    rd(32'h00, 1'b0); step("t5_rd00");
    rd(32'h04, 1'b0); step("t5_rd04");
    rd(32'h3C, 1'b1); step("t5_rd3c");

    rd(32'h14, 1'b0); step("t6_pre");
    reset = 1'b0; #2;
    chk("t6_rst/rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst/rd_data", rd_data, 32'd0);
    chk("t6_rst/busy", 32'(busy), 32'd1);
    last_data = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("t6_part/busy", 32'(busy), 32'd1);
      chk("t6_part/rd_valid", 32'(rd_valid), 32'd0);
    end
    reset = 1'b0; #2;
    chk("t6_mid/busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    run_init(n);
    chk("t6_init_len", 32'(n), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      rd(32'(i * 4), i[0]); step("t6_readback");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
